pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Interlock and forwarding controller for the 5-stage SimpleRisc pipeline (IF, OF, EX, MA, RW), with predict-not-taken branches. It tracks in-flight destination registers in an internal EX/MA/RW shadow pipeline and compares them against the source registers of the instruction in OF. From that comparison it generates:
- load-use stalls,
- branch flushes,
- registered EX-stage forwarding selects,
- combinational RW-to-OF bypass selects.

The operand channel count and register-file size are parameters, so stores, which also read rd, are handled as a third source channel.

## Interface
Parameters:
- NUM_REGS, 16, architectural registers; REG_AW = $clog2(NUM_REGS)
- NUM_SRC, 3, source channels checked per instruction (A, B, store-data)
- CNT_W, 32, width of statistics counters (only with stats compiled in)

Ports (reset is synchronous and active-high; `clk` is the single clock, and all state updates on its rising edge):
- clk  in  1  single clock
- reset  in  1  synchronous active-high reset
- of_valid  in  1  OF holds a real instruction
- of_src  in  NUM_SRC*REG_AW  packed source register numbers, channel 0 in LSBs
- of_src_used  in  NUM_SRC  per-channel "operand read from register file"
- of_rd  in  REG_AW  destination register (15 for call)
- of_wb  in  1  instruction writes a register
- of_is_load  in  1  instruction is ld
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; freezes the whole pipeline
- stall_if_of  out  1  hold PC and IF/OF latch
- bubble_of_ex  out  1  load a NOP (control bus zero) into OF/EX
- flush_if_of  out  1  replace IF/OF latch contents with NOP
- freeze_all  out  1  equals mem_busy; every latch holds
- ex_fwd_sel  out  NUM_SRC*2  registered, per channel: 0 = latched operand, 1 = EX/MA ALU result, 2 = MA/RW result (load or ALU)
- of_rw_byp  out  NUM_SRC  combinational, per channel: take RW write data instead of register-file read
- stat_stalls, stat_flushes  out  CNT_W  (only with HAZ_STATS_EN)

## Operation
- Tracker: slots EX, MA, RW. Each slot holds {valid, rd, wb, is_load}.
- A source channel c matches slot s when all of the following hold:
  - of_valid
  - of_src_used[c]
  - slot s is valid
  - slot s has wb set
  - src[c] equals the slot's rd
- Priority: the youngest slot wins (EX over MA over RW).
- Load-use hazard: any channel matches the EX slot and that slot has is_load set.
  - stall_if_of = 1 and bubble_of_ex = 1.
- Next-cycle forwarding select for channel c:
  - Match in EX (not a load): 1.
  - Else match in MA: 2.
  - Else: 0.
- of_rw_byp[c] = match in RW with no younger match.
- Advance on an ordinary cycle, when freeze_all = 0:
  - RW takes MA, and MA takes EX.
  - EX takes the OF instruction, unless there is a stall, a flush or !of_valid. In those cases EX becomes invalid.
  - ex_fwd_sel is registered with the computed selects. For a bubble or flush it is registered as zero.
- Flush: when ex_branch_taken = 1, flush_if_of = 1 and bubble_of_ex = 1. The OF instruction is discarded and stall_if_of is forced to 0.
- Flush and load-use in the same cycle: flush wins and no stall is asserted.
- Freeze (mem_busy = 1):
  - The tracker and ex_fwd_sel hold.
  - stall_if_of, bubble_of_ex and flush_if_of are all forced to 0.
  - of_rw_byp is still computed.

## Timing
- Reset value of every output and of all tracker/statistics state is 0.
  - Reset asserted mid-operation clears in-flight tracking on the next edge. No stale forwarding survives.
- stall_if_of, bubble_of_ex, flush_if_of and of_rw_byp are combinational, valid in the same cycle as the OF inputs.
- ex_fwd_sel has one-cycle latency: it is valid while the consumer occupies EX.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MA, so the select becomes 2.
- Back-to-back dependent ALU instructions cause zero stalls.
- A branch costs 2 cycles: the IF/OF flush plus the EX bubble.

## Configuration
- HAZ_STATS_EN defined:
  - stat_stalls increments each cycle that stall_if_of = 1.
  - stat_flushes increments each cycle that flush_if_of = 1.
  - Both counters wrap at 2^CNT_W and are cleared by reset.
- HAZ_STATS_EN undefined: the counters and their ports are absent.

## Structure
- Shared package: the tracker-slot typedef, slot indices (SLOT_EX = 0, SLOT_MA = 1, SLOT_RW = 2), forwarding encodings (FWD_NONE, FWD_EXMA, FWD_MARW) and NOP control-bus constant.
- One sub-module: hazard_src_cmp. It handles one channel against all three slots and returns {ld_use, fwd_sel, rw_byp}. It is instantiated NUM_SRC times in a generate loop.

## Test plan
- add r1,r2,r3 followed by sub r4,r1,r5 -> no stall; for channel A, ex_fwd_sel = 1 in the cycle sub is in EX.
- ld r1,4[r2] followed by add r3,r1,r1 -> stall_if_of = 1 and bubble_of_ex = 1 for one cycle; the next cycle has ex_fwd_sel = 2 on channels A and B.
- mov r6,7; nop; st r6,0[r0] -> in the cycle st is in EX, ex_fwd_sel = 2 on the store-data channel. Then mov r6,7; nop; nop; st r6,0[r0] -> in the cycle st is in OF, of_rw_byp = 1 on the store-data channel.
- ex_branch_taken = 1 in the same cycle as a load-use match -> flush_if_of = 1, stall_if_of = 0, and EX is invalid on the next cycle.
- mem_busy held for 3 cycles during a load-use hazard -> tracker and ex_fwd_sel are unchanged and no stall/flush is asserted; after release the stall occurs exactly once.
- Reset asserted while the tracker is full -> all outputs are 0 on the next cycle. With HAZ_STATS_EN, a sequence of 5 stalls and 2 flushes yields stat_stalls = 5 and stat_flushes = 2.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the SimpleRisc hazard/forwarding unit.
package pipe_hazard_unit_pkg;

  // Shadow pipeline geometry: one slot per stage downstream of OF.
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned SLOT_EX   = 0;
  localparam int unsigned SLOT_MA   = 1;
  localparam int unsigned SLOT_RW   = 2;

  // Slot rd field is sized for the largest supported register file (256 regs).
  localparam int unsigned RD_W  = 8;
  localparam int unsigned FWD_W = 2;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wb;
    logic            is_load;
  } slot_t;

  // Bubble/flush content: an all-zero control bus is a NOP.
  localparam slot_t NOP_CTRL = '0;

  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 2'd0,
    FWD_EXMA = 2'd1,
    FWD_MARW = 2'd2
  } fwd_e;

endpackage

// File: rtl/pipe_hazard_unit_src_cmp.sv
// hazard_src_cmp: compares one OF source channel against the EX/MA/RW slots.
module hazard_src_cmp
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic                  active,
  input  logic [REG_AW-1:0]     src,
  input  slot_t [NUM_SLOTS-1:0] slots,
  output logic                  ld_use,
  output fwd_e                  fwd_sel,
  output logic                  rw_byp
);

  logic [NUM_SLOTS-1:0] hit;

  // The load flag is only meaningful for the producer sitting in EX.
  logic unused_ld;
  assign unused_ld = ^{slots[SLOT_MA].is_load, slots[SLOT_RW].is_load};

  // Match against every slot, then resolve youngest-first.
  always_comb begin
    hit     = '0;
    ld_use  = 1'b0;
    fwd_sel = FWD_NONE;
    rw_byp  = 1'b0;
    hit[SLOT_EX] = active && slots[SLOT_EX].valid && slots[SLOT_EX].wb &&
                   (slots[SLOT_EX].rd == RD_W'(src));
    hit[SLOT_MA] = active && slots[SLOT_MA].valid && slots[SLOT_MA].wb &&
                   (slots[SLOT_MA].rd == RD_W'(src));
    hit[SLOT_RW] = active && slots[SLOT_RW].valid && slots[SLOT_RW].wb &&
                   (slots[SLOT_RW].rd == RD_W'(src));
    ld_use = hit[SLOT_EX] && slots[SLOT_EX].is_load;
    if (hit[SLOT_EX]) begin
      if (!slots[SLOT_EX].is_load) fwd_sel = FWD_EXMA;
    end else if (hit[SLOT_MA]) begin
      fwd_sel = FWD_MARW;
    end else begin
      rw_byp = hit[SLOT_RW];
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use interlock, branch flush and operand forwarding
// control for the 5-stage SimpleRisc pipeline.
// Optional: define HAZ_STATS_EN to add stall/flush statistics counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 16,
  parameter  int unsigned NUM_SRC  = 3,
  localparam int unsigned REG_AW   = $clog2(NUM_REGS)
`ifdef HAZ_STATS_EN
  ,
  parameter  int unsigned CNT_W    = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      of_valid,
  input  logic [NUM_SRC*REG_AW-1:0] of_src,
  input  logic [NUM_SRC-1:0]        of_src_used,
  input  logic [REG_AW-1:0]         of_rd,
  input  logic                      of_wb,
  input  logic                      of_is_load,
  input  logic                      ex_branch_taken,
  input  logic                      mem_busy,
  output logic                      stall_if_of,
  output logic                      bubble_of_ex,
  output logic                      flush_if_of,
  output logic                      freeze_all,
  output logic [NUM_SRC*FWD_W-1:0]  ex_fwd_sel,
  output logic [NUM_SRC-1:0]        of_rw_byp
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0]          stat_stalls,
  output logic [CNT_W-1:0]          stat_flushes
`endif
);

  slot_t [NUM_SLOTS-1:0]     slots;
  slot_t                     ex_next;
  logic  [NUM_SRC-1:0]       ld_use_c;
  logic  [NUM_SRC-1:0]       rw_byp_c;
  logic  [NUM_SRC*FWD_W-1:0] fwd_c;

  // One comparator per source channel.
  for (genvar c = 0; c < NUM_SRC; c++) begin : g_src
    fwd_e fwd;
    hazard_src_cmp #(
      .REG_AW (REG_AW)
    ) u_cmp (
      .active  (of_valid && of_src_used[c]),
      .src     (of_src[c*REG_AW +: REG_AW]),
      .slots   (slots),
      .ld_use  (ld_use_c[c]),
      .fwd_sel (fwd),
      .rw_byp  (rw_byp_c[c])
    );
    assign fwd_c[c*FWD_W +: FWD_W] = fwd;
  end

  assign freeze_all = mem_busy;
  assign of_rw_byp  = rw_byp_c;

  // Pipeline control: freeze masks everything, flush beats load-use.
  always_comb begin
    stall_if_of  = 1'b0;
    bubble_of_ex = 1'b0;
    flush_if_of  = 1'b0;
    if (!mem_busy) begin
      flush_if_of  = ex_branch_taken;
      stall_if_of  = (|ld_use_c) && !ex_branch_taken;
      bubble_of_ex = flush_if_of || stall_if_of;
    end
  end

  // Slot entering EX: the OF instruction, or a NOP on bubble/empty OF.
  always_comb begin
    ex_next = NOP_CTRL;
    if (of_valid && !bubble_of_ex) begin
      ex_next.valid   = 1'b1;
      ex_next.rd      = RD_W'(of_rd);
      ex_next.wb      = of_wb;
      ex_next.is_load = of_is_load;
    end
  end

  // Shadow pipeline and registered EX forwarding selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots      <= '0;
      ex_fwd_sel <= '0;
    end else if (!mem_busy) begin
      slots[SLOT_RW] <= slots[SLOT_MA];
      slots[SLOT_MA] <= slots[SLOT_EX];
      slots[SLOT_EX] <= ex_next;
      ex_fwd_sel     <= bubble_of_ex ? '0 : fwd_c;
    end
  end

`ifdef HAZ_STATS_EN
  // Wrapping stall/flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stalls  <= '0;
      stat_flushes <= '0;
    end else begin
      if (stall_if_of) stat_stalls  <= stat_stalls + CNT_W'(1);
      if (flush_if_of) stat_flushes <= stat_flushes + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (covers HAZ_STATS_EN when defined).
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        of_valid;
  logic [11:0] of_src;
  logic [2:0]  of_src_used;
  logic [3:0]  of_rd;
  logic        of_wb;
  logic        of_is_load;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        stall_if_of;
  logic        bubble_of_ex;
  logic        flush_if_of;
  logic        freeze_all;
  logic [5:0]  ex_fwd_sel;
  logic [2:0]  of_rw_byp;
`ifdef HAZ_STATS_EN
  logic [31:0] stat_stalls;
  logic [31:0] stat_flushes;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_unit dut (
    .clk             (clk),
    .reset           (reset),
    .of_valid        (of_valid),
    .of_src          (of_src),
    .of_src_used     (of_src_used),
    .of_rd           (of_rd),
    .of_wb           (of_wb),
    .of_is_load      (of_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .stall_if_of     (stall_if_of),
    .bubble_of_ex    (bubble_of_ex),
    .flush_if_of     (flush_if_of),
    .freeze_all      (freeze_all),
    .ex_fwd_sel      (ex_fwd_sel),
    .of_rw_byp       (of_rw_byp)
`ifdef HAZ_STATS_EN
    ,
    .stat_stalls     (stat_stalls),
    .stat_flushes    (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one instruction in OF: sources A, B, store-data.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic [2:0] used,
                       input logic [3:0] rd, input logic wb, input logic ld);
    of_valid    = v;
    of_src      = {s, b, a};
    of_src_used = used;
    of_rd       = rd;
    of_wb       = wb;
    of_is_load  = ld;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    nop();
    tick();
    tick();
    chk("rst_stall",  32'(stall_if_of),  32'd0);
    chk("rst_bubble", 32'(bubble_of_ex), 32'd0);
    chk("rst_flush",  32'(flush_if_of),  32'd0);
    chk("rst_freeze", 32'(freeze_all),   32'd0);
    chk("rst_fwd",    32'(ex_fwd_sel),   32'd0);
    chk("rst_byp",    32'(of_rw_byp),    32'd0);
    reset = 1'b0;

    // add r1,r2,r3 ; sub r4,r1,r5 -> EX->EX forward on A, no stall
    drive(1, 4'd2, 4'd3, 4'd0, 3'b011, 4'd1, 1, 0);
    chk("alu_add_stall", 32'(stall_if_of), 32'd0);
    tick();
    drive(1, 4'd1, 4'd5, 4'd0, 3'b011, 4'd4, 1, 0);
    chk("alu_sub_stall",  32'(stall_if_of),  32'd0);
    chk("alu_sub_bubble", 32'(bubble_of_ex), 32'd0);
    chk("alu_sub_byp",    32'(of_rw_byp),    32'd0);
    tick();
    nop();
    chk("alu_sub_fwd", 32'(ex_fwd_sel), 32'h01);
    drain();

    // ld r1,4[r2] ; add r3,r1,r1 -> one stall, then MA/RW forward on A and B
    drive(1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1, 1);
    chk("lu_ld_stall", 32'(stall_if_of), 32'd0);
    tick();
    drive(1, 4'd1, 4'd1, 4'd0, 3'b011, 4'd3, 1, 0);
    chk("lu_stall",  32'(stall_if_of),  32'd1);
    chk("lu_bubble", 32'(bubble_of_ex), 32'd1);
    chk("lu_flush",  32'(flush_if_of),  32'd0);
    tick();
    chk("lu_restall", 32'(stall_if_of), 32'd0);
    chk("lu_bub_fwd", 32'(ex_fwd_sel),  32'h00);
    tick();
    nop();
    chk("lu_fwd", 32'(ex_fwd_sel), 32'h0A);
    drain();

    // mov r6,7 ; nop ; st r6,0[r0] -> store-data from MA/RW
    drive(1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1, 0);
    tick();
    nop();
    tick();
    drive(1, 4'd0, 4'd0, 4'd6, 3'b101, 4'd0, 0, 0);
    chk("st1_byp", 32'(of_rw_byp), 32'd0);
    tick();
    nop();
    chk("st1_fwd", 32'(ex_fwd_sel), 32'h20);
    drain();

    // mov r6,7 ; nop ; nop ; st r6,0[r0] -> RW bypass into OF
    drive(1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1, 0);
    tick();
    nop();
    tick();
    tick();
    drive(1, 4'd0, 4'd0, 4'd6, 3'b101, 4'd0, 0, 0);
    chk("st2_byp", 32'(of_rw_byp), 32'b100);
    tick();
    nop();
    chk("st2_fwd", 32'(ex_fwd_sel), 32'h00);
    drain();

    // Branch taken together with a load-use match: flush wins
    drive(1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd7, 1, 1);
    tick();
    ex_branch_taken = 1'b1;
    drive(1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd8, 1, 0);
    chk("br_flush",  32'(flush_if_of),  32'd1);
    chk("br_stall",  32'(stall_if_of),  32'd0);
    chk("br_bubble", 32'(bubble_of_ex), 32'd1);
    tick();
    ex_branch_taken = 1'b0;
    drive(1, 4'd8, 4'd7, 4'd0, 3'b011, 4'd9, 1, 0);
    chk("br_post_stall", 32'(stall_if_of), 32'd0);
    chk("br_post_flush", 32'(flush_if_of), 32'd0);
    chk("br_bub_fwd",    32'(ex_fwd_sel),  32'h00);
    tick();
    nop();
    chk("br_ex_invalid", 32'(ex_fwd_sel), 32'h08);
    drain();

    // mem_busy for 3 cycles over a load-use hazard
    drive(1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1, 0);
    tick();
    drive(1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd9, 1, 1);
    chk("fz_ld_stall", 32'(stall_if_of), 32'd0);
    tick();
    chk("fz_ld_fwd", 32'(ex_fwd_sel), 32'h01);
    mem_busy = 1'b1;
    drive(1, 4'd9, 4'd9, 4'd0, 3'b011, 4'd10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("fz_stall",  32'(stall_if_of),  32'd0);
      chk("fz_bubble", 32'(bubble_of_ex), 32'd0);
      chk("fz_flush",  32'(flush_if_of),  32'd0);
      chk("fz_freeze", 32'(freeze_all),   32'd1);
      chk("fz_fwd",    32'(ex_fwd_sel),   32'h01);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("fz_rel_stall",  32'(stall_if_of),  32'd1);
    chk("fz_rel_bubble", 32'(bubble_of_ex), 32'd1);
    chk("fz_rel_freeze", 32'(freeze_all),   32'd0);
    tick();
    chk("fz_once",    32'(stall_if_of), 32'd0);
    chk("fz_bub_fwd", 32'(ex_fwd_sel),  32'h00);
    tick();
    nop();
    chk("fz_fwd_ma", 32'(ex_fwd_sel), 32'h0A);
    drain();

    // Reset with the tracker full
    drive(1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd11, 1, 0);
    tick();
    drive(1, 4'd11, 4'd0, 4'd0, 3'b001, 4'd12, 1, 0);
    tick();
    drive(1, 4'd12, 4'd0, 4'd0, 3'b001, 4'd13, 1, 0);
    tick();
    drive(1, 4'd13, 4'd12, 4'd11, 3'b111, 4'd0, 0, 0);
    chk("full_fwd",   32'(ex_fwd_sel),  32'h01);
    chk("full_byp",   32'(of_rw_byp),   32'b100);
    chk("full_stall", 32'(stall_if_of), 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_fwd",    32'(ex_fwd_sel),   32'h00);
    chk("mid_rst_byp",    32'(of_rw_byp),    32'd0);
    chk("mid_rst_stall",  32'(stall_if_of),  32'd0);
    chk("mid_rst_bubble", 32'(bubble_of_ex), 32'd0);
    chk("mid_rst_flush",  32'(flush_if_of),  32'd0);
`ifdef HAZ_STATS_EN
    chk("mid_rst_sstall", stat_stalls,  32'd0);
    chk("mid_rst_sflush", stat_flushes, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_fwd", 32'(ex_fwd_sel), 32'h00);
    drain();

    // Five load-use stalls and two flushes
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1, 1);
      tick();
      drive(1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd3, 1, 0);
      chk("cnt_stall", 32'(stall_if_of), 32'd1);
      tick();
      drain();
    end
    for (int k = 0; k < 2; k++) begin
      ex_branch_taken = 1'b1;
      nop();
      chk("cnt_flush", 32'(flush_if_of), 32'd1);
      tick();
      ex_branch_taken = 1'b0;
      nop();
    end
`ifdef HAZ_STATS_EN
    chk("stat_stalls",  stat_stalls,  32'd5);
    chk("stat_flushes", stat_flushes, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
